prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_pkg.sv | 16 +
 rtl/prog_crc8.sv | 57 +++++
 rtl/prog_loader.sv | 197 +++++++++++++++++++
 tb/tb_prog_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Optional CRC check of the payload is enabled by defining PROG_LOADER_CRC_EN.
package prog_pkg;

    localparam int unsigned BYTE_WIDTH = 8;
    localparam logic [BYTE_WIDTH-1:0] CRC8_POLY = 8'h07;

    // Loader sequencing states; the CRC check is a sub-phase of ST_WAIT.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FINISH = 2'd3
    } prog_state_e;

endpackage

// File: rtl/prog_crc8.sv
// Byte-parallel CRC-8 accumulator (poly 0x07, init 0x00, MSB first).
// Only built when PROG_LOADER_CRC_EN is defined; the default build has no CRC logic.
`ifdef PROG_LOADER_CRC_EN
module prog_crc8
    import prog_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic [BYTE_WIDTH-1:0] data_i,
    output logic [BYTE_WIDTH-1:0] crc_o
);

    logic [BYTE_WIDTH-1:0] crc_q;
    logic [BYTE_WIDTH-1:0] crc_d;

    // Fold one whole byte into the running CRC in a single cycle.
    function automatic logic [BYTE_WIDTH-1:0] crc8_update(
        input logic [BYTE_WIDTH-1:0] crc,
        input logic [BYTE_WIDTH-1:0] data
    );
        logic [BYTE_WIDTH-1:0] c;
        c = crc ^ data;
        for (int i = 0; i < int'(BYTE_WIDTH); i++) begin
            if (c[BYTE_WIDTH-1]) begin
                c = {c[BYTE_WIDTH-2:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[BYTE_WIDTH-2:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Next CRC value: clear wins over update.
    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc8_update(crc_q, data_i);
        end
    end

    // CRC register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule
`endif

// File: rtl/prog_loader.sv
// Host-byte to serial loader for an instruction-memory shift register.
// Accepts NUM_BYTES bytes, shifts each out MSB first with a strobe, holds the
// sequencer in reset until the memory image is complete.
// Define PROG_LOADER_CRC_EN to require a trailing CRC-8 byte over the payload.
module prog_loader
    import prog_pkg::*;
#(
    parameter int unsigned MEM_WIDTH = 128,
    parameter int unsigned NUM_BYTES = (MEM_WIDTH + 7) / 8
) (
    input  logic                  clock_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    input  logic [BYTE_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  prog_enable_o,
    output logic                  prog_data_o,
    output logic                  fsm_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int unsigned BCNT_W = $clog2(NUM_BYTES + 2);
    localparam int unsigned BIT_W  = 3;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NUM_BYTES);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(7);

    prog_state_e           state_q, state_d;
    logic [BCNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [BYTE_WIDTH-1:0] shreg_q, shreg_d;
    logic                  hold_q, hold_d;
    logic                  in_ready_q, in_ready_d;
    logic                  prog_en_q, prog_en_d;
    logic                  prog_data_q, prog_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept_c;

`ifdef PROG_LOADER_CRC_EN
    logic                  err_q, err_d;
    logic                  crc_clear_c;
    logic                  crc_en_c;
    logic [BYTE_WIDTH-1:0] crc_val;

    prog_crc8 u_crc8 (
        .clk_i   (clock_i),
        .rst_i   (rst_i),
        .clear_i (crc_clear_c),
        .en_i    (crc_en_c),
        .data_i  (in_data_i),
        .crc_o   (crc_val)
    );
`endif

    assign accept_c = in_valid_i && in_ready_q;

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        hold_d     = hold_q;
`ifdef PROG_LOADER_CRC_EN
        err_d       = err_q;
        crc_clear_c = 1'b0;
        crc_en_c    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_WAIT;
                    byte_cnt_d = '0;
                    bit_cnt_d  = '0;
                    hold_d     = 1'b1;
`ifdef PROG_LOADER_CRC_EN
                    err_d       = 1'b0;
                    crc_clear_c = 1'b1;
`endif
                end
            end

            ST_WAIT: begin
                if (accept_c) begin
`ifdef PROG_LOADER_CRC_EN
                    if (byte_cnt_q == LAST_BYTE) begin
                        // Trailing CRC byte: compared, never shifted.
                        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                        if (in_data_i == crc_val) begin
                            state_d = ST_FINISH;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d    = ST_SHIFT;
                        shreg_d    = in_data_i;
                        bit_cnt_d  = '0;
                        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                        crc_en_c   = 1'b1;
                    end
`else
                    state_d    = ST_SHIFT;
                    shreg_d    = in_data_i;
                    bit_cnt_d  = '0;
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
`endif
                end
            end

            ST_SHIFT: begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                shreg_d   = {shreg_q[BYTE_WIDTH-2:0], 1'b0};
                if (bit_cnt_q == LAST_BIT) begin
`ifdef PROG_LOADER_CRC_EN
                    state_d = ST_WAIT;
`else
                    state_d = (byte_cnt_q < LAST_BYTE) ? ST_WAIT : ST_FINISH;
`endif
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Sequencer is released in the same cycle done is reported.
        if (state_d == ST_FINISH) begin
            hold_d = 1'b0;
        end

        in_ready_d  = (state_d == ST_WAIT);
        prog_en_d   = (state_d == ST_SHIFT);
        prog_data_d = prog_en_d & shreg_d[BYTE_WIDTH-1];
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FINISH);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            hold_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            prog_en_q   <= 1'b0;
            prog_data_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            in_ready_q  <= in_ready_d;
            prog_en_q   <= prog_en_d;
            prog_data_q <= prog_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef PROG_LOADER_CRC_EN
    // Sticky CRC error flag, cleared by reset or the next accepted start.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

    assign in_ready_o    = in_ready_q;
    assign prog_enable_o = prog_en_q;
    assign prog_data_o   = prog_data_q;
    assign fsm_hold_o    = hold_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed loads plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_prog_loader;

`ifdef PROG_LOADER_CRC_EN
    localparam int unsigned MW     = 8;
    localparam bit          CRC_ON = 1'b1;
`else
    localparam int unsigned MW     = 16;
    localparam bit          CRC_ON = 1'b0;
`endif
    localparam int unsigned NB = (MW + 7) / 8;

    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, prog_enable, prog_data, fsm_hold, busy, done, error;

    prog_loader #(.MEM_WIDTH(MW)) dut (
        .clock_i       (clk),
        .rst_i         (rst),
        .start_i       (start),
        .in_valid_i    (in_valid),
        .in_data_i     (in_data),
        .in_ready_o    (in_ready),
        .prog_enable_o (prog_enable),
        .prog_data_o   (prog_data),
        .fsm_hold_o    (fsm_hold),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a load is "active"; accepted bytes become a queue of bits.
    bit         m_active = 1'b0, m_done = 1'b0, m_hold = 1'b0, m_err = 1'b0;
    int         m_taken  = 0;
    bit         bitq[$];
    logic [7:0] m_crc = 8'h00;

    logic [7:0] send_q[$];
    bit         rand_mode = 1'b0;
    int         valid_pct = 60;

    logic [15:0] cap = '0;
    int          cap_n = 0;
    bit          done_seen = 1'b0;
    int          done_cyc = 0, done_cnt = 0, st_cyc = 0;
    int          rdy_q[$];
    logic        exp_pe, exp_pd, exp_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bit-serial CRC-8 (poly 0x07) over a message byte, MSB first.
    function automatic logic [7:0] crc_bits(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    // Model advance on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            chk_en   = 1'b1;
            m_active = 1'b0; m_done = 1'b0; m_hold = 1'b0; m_err = 1'b0;
            m_taken  = 0;
            bitq.delete();
        end else if (m_done) begin
            m_done   = 1'b0;
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_taken = 0; m_hold = 1'b1; m_err = 1'b0; m_crc = 8'h00;
            end
        end else if (bitq.size() != 0) begin
            void'(bitq.pop_front());
            if (bitq.size() == 0 && !CRC_ON && m_taken == int'(NB)) begin
                m_done = 1'b1; m_hold = 1'b0;
            end
        end else if (in_valid) begin
            if (send_q.size() != 0) void'(send_q.pop_front());
            if (m_taken < int'(NB)) begin
                for (int i = 7; i >= 0; i--) bitq.push_back(in_data[i]);
                m_crc = crc_bits(m_crc, in_data);
                m_taken++;
            end else begin
                m_taken++;
                if (in_data == m_crc) begin
                    m_done = 1'b1; m_hold = 1'b0;
                end else begin
                    m_active = 1'b0; m_err = 1'b1;
                end
            end
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_pe  = (bitq.size() != 0);
            exp_pd  = exp_pe ? bitq[0] : 1'b0;
            exp_rdy = m_active && !m_done && !exp_pe;
            chk("in_ready", in_ready, exp_rdy);
            chk("prog_enable", prog_enable, exp_pe);
            chk("prog_data", prog_data, exp_pd);
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("fsm_hold", fsm_hold, m_hold);
            chk("error", error, m_err);
            if (prog_enable === 1'b1) begin
                cap = {cap[14:0], prog_data};
                cap_n++;
            end
            if (done === 1'b1) begin
                done_seen = 1'b1; done_cyc = cyc; done_cnt++;
            end
            if (in_ready === 1'b1) rdy_q.push_back(cyc);
        end
    end

    // Drive one cycle of inputs, then advance to the next falling edge.
    task automatic tick(input bit st, input bit rs);
        start = st;
        rst   = rs;
        if (rand_mode) begin
            in_valid = ($urandom_range(99) < valid_pct);
            in_data  = 8'($urandom);
            if (CRC_ON && m_active && !m_done && bitq.size() == 0 &&
                m_taken == int'(NB) && $urandom_range(1) == 0)
                in_data = m_crc;
        end else begin
            in_valid = (send_q.size() != 0);
            in_data  = (send_q.size() != 0) ? send_q[0] : 8'h00;
        end
        @(negedge clk);
    endtask

    task automatic run_until_done(input int spur, input int max_cyc);
        for (int i = 0; i < max_cyc && !done_seen; i++) tick(i == spur, 1'b0);
    endtask

    task automatic begin_load(input logic [7:0] b0, input logic [7:0] b1, input int nbytes);
        send_q.delete();
        send_q.push_back(b0);
        if (nbytes > 1) send_q.push_back(b1);
        cap = '0; cap_n = 0; done_seen = 1'b0; rdy_q.delete();
        st_cyc = cyc;
        tick(1'b1, 1'b0);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_done_seen"}, done_seen, 1'b1);
        chk({tag, "_stream"}, cap, 16'hA53C);
        chk({tag, "_bits"}, cap_n, 16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clk);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hold", fsm_hold, 1'b0);
        chk("rst_prog_enable", prog_enable, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_error", error, 1'b0);
        tick(1'b0, 1'b0);

`ifndef PROG_LOADER_CRC_EN
        // Two-byte load with bytes always available.
        begin_load(8'hA5, 8'h3C, 2);
        run_until_done(-1, 80);
        check_stream("load");
        chk("latency", done_cyc - st_cyc + 1, 1 + NB * 9 + 1);
        chk("ready_pulses", rdy_q.size(), NB);
        if (rdy_q.size() >= 2) chk("ready_gap", rdy_q[1] - rdy_q[0], 9);
        chk("hold_released", fsm_hold, 1'b0);

        // Start pulsed while byte 0 is shifting is ignored.
        begin_load(8'hA5, 8'h3C, 2);
        run_until_done(3, 80);
        check_stream("busy_start");
        chk("busy_start_latency", done_cyc - st_cyc + 1, 1 + NB * 9 + 1);
`else
        chk("crc_model_pin", crc_bits(8'h00, 8'h01), 8'h07);

        // Good CRC completes the load.
        begin_load(8'h01, 8'h07, 2);
        run_until_done(-1, 60);
        chk("crc_ok_done", done_seen, 1'b1);
        chk("crc_ok_error", error, 1'b0);

        // Bad CRC: error, no done, sequencer held.
        begin_load(8'h01, 8'h06, 2);
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
        chk("crc_bad_no_done", done_seen, 1'b0);
        chk("crc_bad_error", error, 1'b1);
        chk("crc_bad_hold", fsm_hold, 1'b1);
        chk("crc_bad_busy", busy, 1'b0);

        // Next start clears the sticky error.
        begin_load(8'h01, 8'h07, 2);
        chk("crc_err_cleared", error, 1'b0);
        chk("crc_restart_busy", busy, 1'b1);
        run_until_done(-1, 60);
        chk("crc_restart_done", done_seen, 1'b1);
`endif

        // Reset on the 4th shift cycle of byte 0.
        begin_load(8'hA5, 8'h3C, 2);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("midrst_prog_enable", prog_enable, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_hold", fsm_hold, 1'b0);
        chk("midrst_ready", in_ready, 1'b0);
        chk("midrst_bits", cap_n, 4);
        chk("midrst_prefix", cap[3:0], 4'b1010);
        send_q.delete();
        tick(1'b0, 1'b0);
`ifndef PROG_LOADER_CRC_EN
        begin_load(8'hA5, 8'h3C, 2);
        run_until_done(-1, 80);
        check_stream("after_rst");
`else
        begin_load(8'h01, 8'h07, 2);
        run_until_done(-1, 60);
        chk("after_rst_done", done_seen, 1'b1);
`endif

        // Random traffic: starts, gaps, stray bytes and occasional resets.
        rand_mode = 1'b1;
        done_cnt  = 0;
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(14) == 0, $urandom_range(299) == 0);
        rand_mode = 1'b0;
        chk("random_loads_completed", done_cnt > 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
